imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream feeder for the single-cycle core's instruction memory. Takes a byte stream
//  (valid/ready) from a host link and packs bytes little-endian into 32-bit words.
//  Writes each word into instruction memory at consecutive byte addresses 0,4,8,...
//  Holds the core in reset until the whole program is written.
// PARAMETERS
//  MAX_WORDS  64  largest program length accepted, in 32-bit words (1..65535)
//  ADDR_W     64  width of imem_addr; matches PC/Inst_Address width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  rx_data      in   8       stream byte
//  rx_valid     in   1       rx_data valid
//  rx_ready     out  1       loader can accept a byte; a byte transfers when rx_valid&&rx_ready at a clk edge
//  imem_we      out  1       one-cycle instruction-memory write strobe
//  imem_addr    out  ADDR_W  byte address of the write (word_index*4)
//  imem_wdata   out  32      instruction word to write
//  cpu_reset    out  1       drives the core's reset; 1 while loading
//  done         out  1       program fully written
//  error        out  1       bad length header
//  word_count   out  16      number of words written so far
// BEHAVIOUR
//  All outputs registered.
//  Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1,
//   done=0, error=0, word_count=0, state=HDR0, byte/word counters=0.
//  Stream format: length N (16-bit, low byte then high byte), then N*4 data bytes.
//   Each word is sent LSB first.
//  States:
//   HDR0  : rx_ready=1; on transfer latch N[7:0] -> HDR1.
//   HDR1  : rx_ready=1; on transfer latch N[15:8], then check N:
//           N==0 or N>MAX_WORDS -> ERROR; otherwise -> DATA.
//   DATA  : rx_ready=1; byte k (k=0..3) of the current word goes into wdata[8k+7:8k].
//           On the transfer of byte 3, the next cycle has:
//             imem_we=1 for exactly one cycle,
//             imem_addr=word_index*4,
//             imem_wdata=the assembled word,
//             word_count incremented in that same cycle.
//           Partial bytes of the next word may be accepted during the strobe cycle.
//           If byte 3 completes word N-1 -> WRDONE.
//   WRDONE: rx_ready=0; the final imem_we pulse is high in this cycle -> DONE.
//   DONE  : done=1 and cpu_reset=0 from the cycle after the final strobe.
//           rx_ready=0; rx_valid ignored; stays here until reset.
//   ERROR : error=1, rx_ready=0, cpu_reset=1, no writes; stays here until reset.
//  rx_ready drops to 0 in the cycle after the last data byte is transferred; no byte is
//   accepted beyond N*4.
//  rx_valid low: no state change, counters hold (arbitrary gaps allowed).
//  imem_addr/imem_wdata hold their last values when imem_we=0.
//  Reset mid-load (any state):
//   next cycle returns to reset values; partially packed bytes are discarded;
//   the next load restarts at address 0.
//   Already-written memory contents are not cleared.
//  Arithmetic: imem_addr = {word_index,2'b00} zero-extended to ADDR_W;
//   word_index never exceeds MAX_WORDS-1.
// TESTING
//  1. N=2, bytes 02 00 13 05 50 00 b3 05 b5 00 -> imem_we pulses: addr 0 data 00500513,
//     addr 4 data 00b505b3; done=1, cpu_reset=0 one cycle after 2nd pulse; word_count=2.
//  2. Header 00 00 -> error=1, rx_ready=0, no imem_we, cpu_reset stays 1.
//  3. Header 41 00 (N=65 > MAX_WORDS=64) -> error=1, no writes; extra bytes not accepted.
//  4. N=1 with rx_valid toggling every other cycle, word deadbeef -> single pulse,
//     addr 0, data deadbeef; done asserted.
//  5. Reset after 2 data bytes of word 1, then N=1 word 00000013 -> write at addr 0 data 00000013.
//  6. N=64, words = index -> last pulse addr 252 data 0000003f; word_count=64; done=1;
//     rx_ready=0 afterwards.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive and instruction-memory write signals of the boot loader.
// The loader takes the master side; the host link and memory model take the slave side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 64
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a length-prefixed little-endian byte stream into 32-bit instruction words and
// writes them to imem at 0,4,8,...; keeps the core in reset until the program is loaded.
module imem_boot_loader #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 64
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.master  bus,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  output logic [15:0]         word_count
);

  localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRDONE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e            state_q,     state_d;
  logic [7:0]        n_lo_q,      n_lo_d;
  logic [15:0]       n_words_q,   n_words_d;
  logic [1:0]        byte_cnt_q,  byte_cnt_d;
  logic [23:0]       pack_q,      pack_d;
  logic              rx_ready_q,  rx_ready_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;
  logic [15:0]       count_q,     count_d;

  logic              xfer;
  logic [15:0]       n_hdr;

  assign xfer  = bus.rx_valid && rx_ready_q;
  assign n_hdr = {bus.rx_data, n_lo_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR0;
      n_lo_q      <= '0;
      n_words_q   <= '0;
      byte_cnt_q  <= '0;
      pack_q      <= '0;
      rx_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      n_lo_q      <= n_lo_d;
      n_words_q   <= n_words_d;
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_lo_d     = n_lo_q;
    n_words_d  = n_words_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;

    unique case (state_q)
      S_HDR0: begin
        if (xfer) begin
          n_lo_d  = bus.rx_data;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_words_d = n_hdr;
          if ((n_hdr == 16'd0) || (n_hdr > MAX_W16)) state_d = S_ERROR;
          else                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: pack_d[7:0]   = bus.rx_data;
            2'd1: pack_d[15:8]  = bus.rx_data;
            2'd2: pack_d[23:16] = bus.rx_data;
            2'd3: begin
              // Word complete: strobe lands on the next cycle while the next word's
              // bytes may already be arriving.
              we_d    = 1'b1;
              addr_d  = ADDR_W'({count_q, 2'b00});
              wdata_d = {bus.rx_data, pack_q};
              count_d = count_q + 16'd1;
              if (count_q == n_words_q - 16'd1) state_d = S_WRDONE;
            end
            default: ;
          endcase
        end
      end
      S_WRDONE: state_d = S_DONE;
      S_DONE:   state_d = S_DONE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_HDR0;
    endcase

    // Status outputs are registered images of the state being entered.
    rx_ready_d  = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    cpu_reset_d = (state_d != S_DONE);
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign word_count     = count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized load sequences for imem_boot_loader, checked against a
// byte-list reference model of the expected memory writes and final status.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 64;
  localparam int MAX_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_reset, done, error;
  logic [15:0] word_count;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed write pulses, captured away from the active edge
  logic [63:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [15:0] got_cnt[$];
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_we) begin
      got_addr.push_back(64'(bus.imem_addr));
      got_data.push_back(bus.imem_wdata);
      got_cnt.push_back(word_count);
      last_we_cyc <= cyc;
    end
    if (done && !done_prev) done_rise_cyc <= cyc;
    done_prev <= done;
  end

  logic [7:0] stim[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rx_ready"},   64'(bus.rx_ready),   64'd0);
    check({tag, ".imem_we"},    64'(bus.imem_we),    64'd0);
    check({tag, ".imem_addr"},  64'(bus.imem_addr),  64'd0);
    check({tag, ".imem_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, ".cpu_reset"},  64'(cpu_reset),      64'd1);
    check({tag, ".done"},       64'(done),           64'd0);
    check({tag, ".error"},      64'(error),          64'd0);
    check({tag, ".word_count"}, 64'(word_count),     64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int bound, input int gaps, output bit ok);
    repeat (gaps) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (bus.rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Feeds stim[] and checks the outcome against the model. gap_mode: 0 none,
  // 1 valid low every other cycle, 2 random idle gaps.
  task automatic run_load(input string tag, input int gap_mode);
    int          n, n_acc;
    bit          bad, ok, all_ok, none_extra;
    logic [63:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          gaps;

    got_addr.delete(); got_data.delete(); got_cnt.delete();
    last_we_cyc   = -1;
    done_rise_cyc = -1;

    n   = int'(stim[0]) + 256 * int'(stim[1]);
    bad = (n == 0) || (n > MAX_WORDS);
    n_acc = bad ? 2 : 2 + 4 * n;
    if (!bad)
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(64'(4 * i));
        exp_data.push_back(32'(stim[2+4*i]) + 32'(stim[3+4*i]) * 32'h100 +
                           32'(stim[4+4*i]) * 32'h10000 + 32'(stim[5+4*i]) * 32'h1000000);
      end

    all_ok = 1'b1;
    none_extra = 1'b1;
    for (int i = 0; i < stim.size(); i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (i < n_acc) begin
        push_byte(stim[i], 50, gaps, ok);
        if (!ok) all_ok = 1'b0;
      end else begin
        push_byte(stim[i], 8, gaps, ok);
        if (ok) none_extra = 1'b0;
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (4) @(negedge clk);

    check({tag, ".accepted_all"}, 64'(all_ok), 64'd1);
    if (stim.size() > n_acc) check({tag, ".no_extra_byte"}, 64'(none_extra), 64'd1);
    check({tag, ".n_writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s.addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s.data[%0d]", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      check($sformatf("%s.cnt[%0d]", tag, i), 64'(got_cnt[i]), 64'(i + 1));
    end
    check({tag, ".done"},       64'(done),         bad ? 64'd0 : 64'd1);
    check({tag, ".error"},      64'(error),        bad ? 64'd1 : 64'd0);
    check({tag, ".cpu_reset"},  64'(cpu_reset),    bad ? 64'd1 : 64'd0);
    check({tag, ".rx_ready"},   64'(bus.rx_ready), 64'd0);
    check({tag, ".imem_we"},    64'(bus.imem_we),  64'd0);
    check({tag, ".word_count"}, 64'(word_count),   bad ? 64'd0 : 64'(n));
    if (!bad) begin
      check({tag, ".done_timing"}, 64'(done_rise_cyc), 64'(last_we_cyc + 1));
      check({tag, ".addr_hold"},   64'(bus.imem_addr), exp_addr[n-1]);
      check({tag, ".wdata_hold"},  64'(bus.imem_wdata), 64'(exp_data[n-1]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit ok;
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Two-word program
    stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'hb3, 8'h05, 8'hb5, 8'h00, 8'h77};
    run_load("t1", 0);

    do_reset();
    stim = '{8'h00, 8'h00, 8'h11};
    run_load("t2_zero", 0);

    do_reset();
    stim = '{8'h41, 8'h00, 8'h01, 8'h02, 8'h03};
    run_load("t3_big", 2);

    do_reset();
    stim = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde};
    run_load("t4_gaps", 1);

    // Reset part-way through a word, then reload from address 0
    do_reset();
    got_addr.delete();
    push_byte(8'h01, 50, 0, ok);
    push_byte(8'h00, 50, 0, ok);
    push_byte(8'haa, 50, 0, ok);
    push_byte(8'hbb, 50, 0, ok);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("t5_midreset");
    check("t5.no_partial_write", 64'(got_addr.size()), 64'd0);
    reset = 1'b0;
    stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    run_load("t5_reload", 0);

    // Maximum-length program, word i = i
    do_reset();
    stim = '{8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      stim.push_back(8'(i)); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00);
    end
    stim.push_back(8'h5a);
    run_load("t6_max", 2);

    // Random legal programs
    for (int r = 0; r < 4; r++) begin
      do_reset();
      n = int'($urandom_range(1, 8));
      stim = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n + 2; i++) stim.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", r), 2);
    end

    // Random oversize header
    do_reset();
    n = int'($urandom_range(MAX_WORDS + 1, 65535));
    stim = '{8'(n), 8'(n >> 8), 8'($urandom), 8'($urandom)};
    run_load("rnd_big", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
